// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : pops 16-bit FIFO words and sends each as two 8N1 UART bytes.
// Revision 1.0
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        EMPTY,
    input  logic        VALID,
    input  logic [15:0] DIN,
    output logic        RD,
    output logic        TXD,
    output logic        BUSY,
    output logic        ERR,
    output logic [7:0]  SENT_CNT
);

    localparam logic [15:0] C_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  C_IDX_STOP = 4'd9;
    localparam logic [3:0]  C_IDX_D7   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LO   = 3'd3,
        S_HI   = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic [3:0]  idx_q;
    logic [15:0] shift_q;
    logic        rd_q;
    logic        txd_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            rd_q    <= 1'b0;
            txd_q   <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rd_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (EN && !EMPTY) begin
                        state_q <= S_REQ;
                        rd_q    <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (VALID) begin
                        shift_q <= DIN;
                        state_q <= S_LO;
                        txd_q   <= 1'b0;
                        timer_q <= C_BIT_LAST;
                        idx_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                S_LO, S_HI: begin
                    if (timer_q != 16'd0) begin
                        timer_q <= timer_q - 16'd1;
                    end else begin
                        timer_q <= C_BIT_LAST;
                        if (idx_q == C_IDX_STOP) begin
                            idx_q <= '0;
                            if (state_q == S_LO) begin
                                // HI start bit follows the LO stop bit with no gap
                                state_q <= S_HI;
                                txd_q   <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                txd_q   <= 1'b1;
                                cnt_q   <= cnt_q + 8'd1;
                            end
                        end else if (idx_q == C_IDX_D7) begin
                            idx_q <= idx_q + 4'd1;
                            txd_q <= 1'b1;
                        end else begin
                            // after eight shifts the high byte sits in shift_q[7:0]
                            idx_q   <= idx_q + 4'd1;
                            txd_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[15:1]};
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign RD       = rd_q;
    assign TXD      = txd_q;
    assign BUSY     = (state_q != S_IDLE);
    assign ERR      = err_q;
    assign SENT_CNT = cnt_q;

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 16-bit, 8-deep FIFO. Whenever the FIFO is non-empty and the block is enabled, it pops one word using the FIFO's RD/VALID read protocol. It then transmits the word on a single UART line as two 8N1 bytes, low byte first. Together with the FIFO, it forms the board's data-out path to the host serial link.

## Interface
- CLKS_PER_BIT, default 868: CLK cycles per UART bit. Legal range 2..65535, which is 115200 baud at 100 MHz.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  drain enable; sampled only in IDLE.
- EMPTY  in  1  FIFO EMPTY flag.
- VALID  in  1  FIFO VALID; high in the cycle DIN holds popped data.
- DIN  in  16  FIFO DOUT.
- RD  out  1  FIFO read request; registered, one-cycle pulse.
- TXD  out  1  UART serial output; idle high.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse when VALID is missing after RD.
- SENT_CNT  out  8  count of completed words; wraps 255->0.

## Operation
- States:
  - IDLE -> REQ when EN=1 && EMPTY=0.
  - REQ -> WAIT unconditionally; RD=1 only in REQ.
  - WAIT -> LO if VALID=1, and DIN is latched into the 16-bit shift register. WAIT -> IDLE if VALID=0, with ERR pulsed and nothing transmitted.
  - LO -> HI after 10 bits.
  - HI -> IDLE after 10 bits; SENT_CNT increments on this transition.
- Frame per byte: start bit (0), data bits 0..7 LSB first, stop bit (1).
  - LO sends DIN[7:0].
  - HI sends DIN[15:8].
  - No idle gap between the LO stop bit and the HI start bit.
- Bit timer: 16-bit down-counter loaded with CLKS_PER_BIT-1 at each bit start. The bit advances when the counter reaches 0.
- Bit index: 4-bit counter 0..9 per byte, holding start, d0..d7, stop.
- TXD is registered and driven 1 in IDLE, REQ and WAIT.
- EN is ignored outside IDLE. Deasserting EN mid-word lets the word finish, then the block holds in IDLE.
- RD is never asserted while EMPTY=1 in IDLE, so this block never causes FIFO UNDER.
- One word is in flight at a time; no pop is issued before the HI stop bit completes.

## Timing
- Reset values: RD=0, TXD=1, BUSY=0, ERR=0, SENT_CNT=0, state IDLE.
- Reset mid-frame: on the next edge TXD=1 and state is IDLE. The word in flight is dropped, and SENT_CNT is cleared.
- Let cycle 0 be the IDLE cycle with EN=1 and EMPTY=0:
  - cycle 1: RD=1, BUSY=1.
  - cycle 2: VALID expected; DIN captured at the end of this cycle.
  - cycle 3: TXD=0, start of the LO start bit.
  - TXD holds each bit for exactly CLKS_PER_BIT cycles.
  - The HI stop bit ends after cycle 2+20*CLKS_PER_BIT.
  - Cycle 3+20*CLKS_PER_BIT: back in IDLE, BUSY=0, SENT_CNT updated. EMPTY is sampled this cycle, so back-to-back words have 3 idle-high cycles between frames (IDLE, REQ, WAIT).
- ERR path: at the end of cycle 2, VALID=0 -> state IDLE in cycle 3 with ERR=1 for exactly that cycle.
- The EMPTY flag updates on the same edge that VALID rises, so IDLE always sees a current EMPTY.

## Test plan
- Single word: CLKS_PER_BIT=4, FIFO holds 16'hA55A, EN=1.
  - RD pulses once.
  - TXD emits 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - SENT_CNT=1.
  - BUSY is high for 3+80-1 cycles.
- Burst: FIFO holds 8 words 16'h0001..16'h0008.
  - 8 RD pulses, each issued only after the previous HI stop bit.
  - Bytes decoded by the bench UART model are 01,00,02,00,…,08,00.
  - SENT_CNT=8, then idle with EMPTY=1.
- EN gating: EN=0 with FIFO non-empty -> no RD and TXD=1 for 100 cycles. Raise EN -> RD 1 cycle later. Drop EN during LO -> the word completes and no further RD follows.
- Missing VALID: force VALID=0 after RD -> ERR pulse in cycle 3, TXD stays 1, SENT_CNT unchanged, and the next pop proceeds normally.
- Reset mid-frame: assert RST during HI data bit 3 -> next cycle TXD=1, BUSY=0, SENT_CNT=0. After release, the next FIFO word transmits correctly.
- Counter wrap: transmit 256 words with CLKS_PER_BIT=2 -> SENT_CNT reads 0 after word 256, with no RD issued on an empty FIFO (FIFO UNDER never asserted).
